// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, and data-memory wait freezes.
// Control outputs are zero-latency from state and inputs; MemTimeout and StallCount are registered.
module hazard_stall_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] D_rs1,
  input  logic [REG_W-1:0] D_rs2,
  input  logic             D_UsesRs1,
  input  logic             D_UsesRs2,
  input  logic             E_MemRead,
  input  logic [REG_W-1:0] E_rd,
  input  logic             E_BranchTaken,
  input  logic             M_MemReq,
  input  logic             M_MemReady,
  output logic             D_PCWrite,
  output logic             D_IFIDWrite,
  output logic             D_Flush,
  output logic             E_Bubble,
  output logic             M_Freeze,
  output logic             MemTimeout,
  output logic [15:0]      StallCount
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       timeout_nxt;
  logic       load_use, mem_wait, freeze_cond;

  assign load_use = E_MemRead && (E_rd != '0) &&
                    ((D_UsesRs1 && (D_rs1 == E_rd)) || (D_UsesRs2 && (D_rs2 == E_rd)));
  assign mem_wait = M_MemReq && !M_MemReady;

  // In MEM_WAIT only readiness matters; a new request is not considered until back in RUN.
  assign freeze_cond = (state == RUN) ? mem_wait : !M_MemReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wcnt       <= 8'd0;
      MemTimeout <= 1'b0;
      StallCount <= 16'd0;
    end else begin
      state      <= state_nxt;
      wcnt       <= wcnt_nxt;
      MemTimeout <= timeout_nxt;
      if (!D_PCWrite && (StallCount != 16'hFFFF))
        StallCount <= StallCount + 16'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    timeout_nxt = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (M_MemReady) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt >= WAIT_LIMIT) begin
          state_nxt   = RUN;
          wcnt_nxt    = 8'd0;
          timeout_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  always_comb begin
    D_PCWrite   = 1'b1;
    D_IFIDWrite = 1'b1;
    D_Flush     = 1'b0;
    E_Bubble    = 1'b0;
    M_Freeze    = 1'b0;
    if (rst) begin
      D_PCWrite   = 1'b0;
      D_IFIDWrite = 1'b0;
    end else if (freeze_cond) begin
      D_PCWrite   = 1'b0;
      D_IFIDWrite = 1'b0;
      M_Freeze    = 1'b1;
    end else if (E_BranchTaken) begin
      D_Flush  = 1'b1;
      E_Bubble = 1'b1;
    end else if (load_use) begin
      D_PCWrite   = 1'b0;
      D_IFIDWrite = 1'b0;
      E_Bubble    = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed per-cycle vectors feed an expectation queue,
// and a negedge monitor pops one entry per cycle and compares against the DUT.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  D_rs1 = '0, D_rs2 = '0, E_rd = '0;
  logic        D_UsesRs1 = 0, D_UsesRs2 = 0, E_MemRead = 0, E_BranchTaken = 0;
  logic        M_MemReq = 0, M_MemReady = 0;
  logic        D_PCWrite, D_IFIDWrite, D_Flush, E_Bubble, M_Freeze, MemTimeout;
  logic [15:0] StallCount;

  hazard_stall_ctrl #(.REG_W(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .D_rs1(D_rs1), .D_rs2(D_rs2), .D_UsesRs1(D_UsesRs1), .D_UsesRs2(D_UsesRs2),
    .E_MemRead(E_MemRead), .E_rd(E_rd), .E_BranchTaken(E_BranchTaken),
    .M_MemReq(M_MemReq), .M_MemReady(M_MemReady),
    .D_PCWrite(D_PCWrite), .D_IFIDWrite(D_IFIDWrite), .D_Flush(D_Flush),
    .E_Bubble(E_Bubble), .M_Freeze(M_Freeze), .MemTimeout(MemTimeout),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // Expected {PCWrite, IFIDWrite, Flush, Bubble, Freeze, MemTimeout}
  localparam logic [5:0] RUNO = 6'b110000;
  localparam logic [5:0] RUNT = 6'b110001;
  localparam logic [5:0] FRZ  = 6'b000010;
  localparam logic [5:0] LUO  = 6'b000100;
  localparam logic [5:0] BRO  = 6'b111100;
  localparam logic [5:0] ZERO = 6'b000000;

  typedef struct {
    string       nm;
    logic [4:0]  o;
    logic        tmo;
    logic [15:0] cnt;
    logic        known;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mcnt   = 16'd0;
  logic        known  = 1'b0;

  task automatic cyc(input string nm, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic mrd, input logic [4:0] erd,
                     input logic br, input logic mq, input logic my, input logic [5:0] ex);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; D_rs1 = rs1; D_rs2 = rs2; D_UsesRs1 = u1; D_UsesRs2 = u2;
    E_MemRead = mrd; E_rd = erd; E_BranchTaken = br; M_MemReq = mq; M_MemReady = my;
    e.nm = nm; e.o = ex[5:1]; e.tmo = ex[0]; e.cnt = mcnt; e.known = known;
    q.push_back(e);
    if (r) begin
      mcnt  = 16'd0;
      known = 1'b1;
    end else if (!ex[5] && mcnt != 16'hFFFF) begin
      mcnt = mcnt + 16'd1;
    end
  endtask

  task automatic idle(input string nm, input logic [5:0] ex);
    cyc(nm, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, ex);
  endtask

  task automatic mem(input string nm, input logic mq, input logic my, input logic br,
                     input logic lu, input logic [5:0] ex);
    cyc(nm, 0, lu ? 5'd7 : 5'd0, 5'd0, lu, 0, lu, lu ? 5'd7 : 5'd0, br, mq, my, ex);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({D_PCWrite, D_IFIDWrite, D_Flush, E_Bubble, M_Freeze} !== e.o) begin
          errors++;
          $display("FAIL %s ctl got %b want %b", e.nm,
                   {D_PCWrite, D_IFIDWrite, D_Flush, E_Bubble, M_Freeze}, e.o);
        end
        if (e.known) begin
          checks++;
          if (MemTimeout !== e.tmo || StallCount !== e.cnt) begin
            errors++;
            $display("FAIL %s tmo/cnt got %b/%0d want %b/%0d", e.nm,
                     MemTimeout, StallCount, e.tmo, e.cnt);
          end
        end
      end
    end
  end

  initial begin : driver
    cyc("rst0", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, ZERO);
    cyc("rst1", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, ZERO);
    idle("post_rst", RUNO);

    // Load-use, then x0 and unused-operand cases, then rs2 match
    cyc("lu_rs1", 0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, LUO);
    idle("lu_after", RUNO);
    cyc("x0", 0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, RUNO);
    cyc("unused_rs1", 0, 5'd5, 5'd9, 0, 1, 1, 5'd5, 0, 0, 0, RUNO);
    cyc("no_load", 0, 5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 0, 0, RUNO);
    cyc("lu_rs2", 0, 5'd1, 5'd12, 1, 1, 1, 5'd12, 0, 0, 0, LUO);

    // Three-cycle memory wait released in the ready cycle
    mem("mw1", 1, 0, 0, 0, FRZ);
    mem("mw2", 1, 0, 0, 0, FRZ);
    mem("mw3", 1, 0, 0, 0, FRZ);
    mem("mw_rdy", 1, 1, 0, 0, RUNO);
    idle("mw_after", RUNO);

    // Priority: MW over branch over load-use; events ignored while waiting
    mem("pri_all", 1, 0, 1, 1, FRZ);
    mem("wait_br", 0, 0, 1, 0, FRZ);
    mem("rel_br_lu", 1, 1, 1, 1, BRO);
    mem("br_lu", 0, 0, 1, 1, BRO);
    mem("mw_again", 1, 0, 0, 0, FRZ);
    mem("rel_lu", 0, 1, 0, 1, LUO);
    idle("pri_after", RUNO);

    // Timeout after WCnt reaches 4, then re-entry into MEM_WAIT
    mem("to1", 1, 0, 0, 0, FRZ);
    mem("to2", 1, 0, 0, 0, FRZ);
    mem("to3", 1, 0, 0, 0, FRZ);
    mem("to4", 1, 0, 0, 0, FRZ);
    mem("to5", 1, 0, 0, 0, FRZ);
    idle("to_pulse", RUNT);
    idle("to_once", RUNO);
    mem("reenter", 1, 0, 0, 0, FRZ);
    mem("in_wait", 0, 0, 0, 0, FRZ);
    mem("re_rdy", 0, 1, 0, 0, RUNO);

    // Reset at the cycle that would otherwise abort the wait
    mem("rw1", 1, 0, 0, 0, FRZ);
    mem("rw2", 1, 0, 0, 0, FRZ);
    mem("rw3", 1, 0, 0, 0, FRZ);
    mem("rw4", 1, 0, 0, 0, FRZ);
    cyc("rw_rst", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, ZERO);
    idle("rw_post", RUNO);
    idle("rw_post2", RUNO);

    // Long load-use stall saturates StallCount
    for (int i = 0; i < 65540; i++)
      cyc("sat", 0, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0, LUO);
    idle("sat_hold", RUNO);
    idle("sat_hold2", RUNO);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
